// File: rtl/set_ctrl.sv
// Front-end control for the millennium clock: debounces the mode/up/down buttons,
// walks the edit field selector and produces the en_1 tick and up/down pulses.
module set_ctrl #(
  parameter int unsigned DEBOUNCE_CYC = 4,
  parameter int unsigned TICK_DIV     = 10,
  parameter int unsigned REPEAT_DLY   = 20,
  parameter int unsigned REPEAT_RATE  = 5,
  parameter int unsigned TIMEOUT_CYC  = 200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_mode,
  input  logic       btn_up,
  input  logic       btn_down,
  output logic       en_1,
  output logic       up,
  output logic       down,
  output logic [2:0] select_item,
  output logic       editing
);

  localparam int unsigned DB_W   = $clog2(DEBOUNCE_CYC + 1);
  localparam int unsigned PS_W   = $clog2(TICK_DIV + 1);
  localparam int unsigned RP_MAX = (REPEAT_DLY > REPEAT_RATE) ? REPEAT_DLY : REPEAT_RATE;
  localparam int unsigned RP_W   = $clog2(RP_MAX + 1);
  localparam int unsigned TO_W   = $clog2(TIMEOUT_CYC + 1);
  localparam int unsigned B_MODE = 0;
  localparam int unsigned B_UP   = 1;
  localparam int unsigned B_DOWN = 2;

  typedef enum logic [2:0] {
    S_SEC   = 3'b000,
    S_MIN   = 3'b001,
    S_HOUR  = 3'b010,
    S_DAY   = 3'b011,
    S_MONTH = 3'b100,
    S_YEAR  = 3'b101,
    S_RUN   = 3'b111
  } state_t;

  logic [2:0]      sync1, sync2, deb, deb_d;
  logic [DB_W-1:0] db_cnt [3];
  logic [2:0]      press_c;

  // Synchronize each button, then accept a level change only after it has held long enough
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
      deb   <= '0;
      deb_d <= '0;
      for (int i = 0; i < 3; i++) db_cnt[i] <= '0;
    end else begin
      sync1 <= {btn_down, btn_up, btn_mode};
      sync2 <= sync1;
      deb_d <= deb;
      for (int i = 0; i < 3; i++) begin
        if (sync2[i] == deb[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_W'(DEBOUNCE_CYC - 1)) begin
          deb[i]    <= ~deb[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + DB_W'(1);
        end
      end
    end
  end

  assign press_c = deb & ~deb_d;

  state_t          state_q, state_d;
  logic [PS_W-1:0] presc_q, presc_d;
  logic [RP_W-1:0] rpt_cnt_q, rpt_cnt_d;
  logic [TO_W-1:0] idle_q, idle_d;
  logic            rpt_on_q, rpt_on_d, rpt_fast_q, rpt_fast_d, rpt_up_q, rpt_up_d;
  logic            en_d, up_d, down_d, editing_d;
  logic            up_only, down_only, timeout, rpt_hit;

  function automatic state_t next_field(input state_t s);
    case (s)
      S_SEC:   next_field = S_MIN;
      S_MIN:   next_field = S_HOUR;
      S_HOUR:  next_field = S_DAY;
      S_DAY:   next_field = S_MONTH;
      S_MONTH: next_field = S_YEAR;
      S_YEAR:  next_field = S_RUN;
      default: next_field = S_SEC;
    endcase
  endfunction

  always_comb begin
    state_d    = state_q;
    presc_d    = '0;
    rpt_cnt_d  = '0;
    rpt_on_d   = 1'b0;
    rpt_fast_d = 1'b0;
    rpt_up_d   = rpt_up_q;
    idle_d     = '0;
    en_d       = 1'b0;
    up_d       = 1'b0;
    down_d     = 1'b0;
    editing_d  = 1'b0;
    timeout    = 1'b0;
    rpt_hit    = 1'b0;
    up_only    = deb[B_UP] & ~deb[B_DOWN];
    down_only  = deb[B_DOWN] & ~deb[B_UP];

    if (state_q == S_RUN) begin
      presc_d = (presc_q == PS_W'(TICK_DIV - 1)) ? '0 : presc_q + PS_W'(1);
      if (press_c[B_MODE]) state_d = S_SEC;
    end else begin
      // Idle time only accumulates while every button is released
      if (deb == 3'b000) begin
        if (idle_q == TO_W'(TIMEOUT_CYC - 1)) timeout = 1'b1;
        else                                  idle_d  = idle_q + TO_W'(1);
      end

      if (press_c[B_MODE]) begin
        state_d = next_field(state_q);
      end else if (timeout) begin
        state_d = S_RUN;
      end else if (press_c[B_UP] ^ press_c[B_DOWN]) begin
        up_d     = press_c[B_UP];
        down_d   = press_c[B_DOWN];
        rpt_on_d = 1'b1;
        rpt_up_d = press_c[B_UP];
      end else if (rpt_on_q && (rpt_up_q ? up_only : down_only)) begin
        // Repeat is armed only by an initial pulse and survives only while that button is held alone
        rpt_on_d   = 1'b1;
        rpt_fast_d = rpt_fast_q;
        rpt_hit    = (rpt_cnt_q == (rpt_fast_q ? RP_W'(REPEAT_RATE - 1) : RP_W'(REPEAT_DLY - 1)));
        if (rpt_hit) begin
          up_d       = rpt_up_q;
          down_d     = ~rpt_up_q;
          rpt_fast_d = 1'b1;
        end else begin
          rpt_cnt_d  = rpt_cnt_q + RP_W'(1);
        end
      end
    end

    en_d      = (state_d == S_RUN) && (presc_d == PS_W'(TICK_DIV - 1));
    editing_d = (state_d != S_RUN);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_RUN;
      presc_q    <= '0;
      rpt_cnt_q  <= '0;
      rpt_on_q   <= 1'b0;
      rpt_fast_q <= 1'b0;
      rpt_up_q   <= 1'b0;
      idle_q     <= '0;
      en_1       <= 1'b0;
      up         <= 1'b0;
      down       <= 1'b0;
      editing    <= 1'b0;
    end else begin
      state_q    <= state_d;
      presc_q    <= presc_d;
      rpt_cnt_q  <= rpt_cnt_d;
      rpt_on_q   <= rpt_on_d;
      rpt_fast_q <= rpt_fast_d;
      rpt_up_q   <= rpt_up_d;
      idle_q     <= idle_d;
      en_1       <= en_d;
      up         <= up_d;
      down       <= down_d;
      editing    <= editing_d;
    end
  end

  assign select_item = state_q;

endmodule

// File: tb/tb_set_ctrl.sv
// Bench for set_ctrl: directed scenarios plus random button activity, every cycle
// compared against an event-level reference model of the control stage.
module tb_set_ctrl;

  localparam int DEB  = 4;
  localparam int TICK = 10;
  localparam int DLY  = 20;
  localparam int RATE = 5;
  localparam int TMO  = 200;
  localparam int RUN  = 6;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       btn_mode = 1'b0, btn_up = 1'b0, btn_down = 1'b0;
  logic       en_1, up, down, editing;
  logic [2:0] select_item;

  set_ctrl #(
    .DEBOUNCE_CYC(DEB), .TICK_DIV(TICK), .REPEAT_DLY(DLY),
    .REPEAT_RATE(RATE), .TIMEOUT_CYC(TMO)
  ) dut (
    .clk(clk), .rst(rst), .btn_mode(btn_mode), .btn_up(btn_up), .btn_down(btn_down),
    .en_1(en_1), .up(up), .down(down), .select_item(select_item), .editing(editing)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: field index 0..5 edit, 6 run; times are edge counts since reset
  int           t, rs, last_act, last_pulse, nth, burst, m_sel;
  bit [2:0]     m_s1, m_deb, m_deb_prev;
  bit [DEB-1:0] m_win [3];
  bit           exp_en, exp_up, exp_dn;

  task automatic model_reset();
    t = 0; rs = 0; last_act = 0; last_pulse = 0; nth = 0; burst = 0; m_sel = RUN;
    m_s1 = '0; m_deb = '0; m_deb_prev = '0;
    for (int b = 0; b < 3; b++) m_win[b] = '0;
    exp_en = 1'b0; exp_up = 1'b0; exp_dn = 1'b0;
  endtask

  task automatic model_step();
    bit [2:0] raw, prs, dbv, nd;
    bit any, up_only, dn_only, tmo;
    raw = {btn_down, btn_up, btn_mode};
    dbv = m_deb;
    prs = m_deb & ~m_deb_prev;
    t++;
    exp_up = 1'b0;
    exp_dn = 1'b0;
    any = |dbv;
    if (any) last_act = t;
    if (m_sel == RUN) begin
      burst = 0;
      if (prs[0]) m_sel = 0;
    end else begin
      tmo     = !any && (t - last_act == TMO);
      up_only = dbv[1] && !dbv[2];
      dn_only = dbv[2] && !dbv[1];
      if (prs[0]) begin
        m_sel++;
        burst = 0;
        if (m_sel == RUN) rs = t;
      end else if (tmo) begin
        m_sel = RUN;
        rs = t;
        burst = 0;
      end else if (prs[1] != prs[2]) begin
        exp_up = prs[1];
        exp_dn = prs[2];
        burst = prs[1] ? 1 : 2;
        last_pulse = t;
        nth = 0;
      end else if ((burst == 1 && up_only) || (burst == 2 && dn_only)) begin
        if (t - last_pulse == ((nth == 0) ? DLY : RATE)) begin
          exp_up = (burst == 1);
          exp_dn = (burst == 2);
          last_pulse = t;
          nth++;
        end
      end else begin
        burst = 0;
      end
    end
    exp_en = (m_sel == RUN) && ((t - rs) % TICK == TICK - 1);
    // A button's accepted level flips once the synchronized level has disagreed for DEB edges
    for (int b = 0; b < 3; b++) begin
      bit all_diff;
      all_diff = 1'b1;
      for (int k = 0; k < DEB; k++) if (m_win[b][k] == m_deb[b]) all_diff = 1'b0;
      nd[b] = all_diff ? ~m_deb[b] : m_deb[b];
      m_win[b] = {m_win[b][DEB-2:0], m_s1[b]};
    end
    m_s1 = raw;
    m_deb_prev = m_deb;
    m_deb = nd;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or posedge rst);
      if (rst) model_reset();
      else     model_step();
    end
  end

  int up_cnt = 0, dn_cnt = 0, en_cnt = 0;

  initial begin
    logic [2:0] e_sel;
    forever begin
      @(negedge clk);
      e_sel = (m_sel == RUN) ? 3'b111 : 3'(m_sel);
      check("outs", 32'({en_1, up, down, select_item, editing}),
            32'({exp_en, exp_up, exp_dn, e_sel, (m_sel != RUN)}));
      if (up)   up_cnt++;
      if (down) dn_cnt++;
      if (en_1) en_cnt++;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic push(input bit m, input bit u, input bit d, input int len, input int gap);
    btn_mode = m; btn_up = u; btn_down = d;
    tick(len);
    btn_mode = 1'b0; btn_up = 1'b0; btn_down = 1'b0;
    tick(gap);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, k;
    bit found;
    int en_at [3];
    int sel_tab [7] = '{0, 1, 2, 3, 4, 5, 7};

    tick(3);
    check("reset_sel", 32'(select_item), 32'h7);
    check("reset_flags", 32'({en_1, up, down, editing}), 32'h0);
    rst = 1'b0;

    // Free-running ticks: cycle i+1 is the cycle following the i-th edge after release
    up_cnt = 0; dn_cnt = 0; k = 0;
    for (int i = 1; i <= 30; i++) begin
      tick(1);
      if (en_1 && k < 3) begin en_at[k] = i + 1; k++; end
    end
    check("en_count", 32'(k), 32'd3);
    check("en_cycle0", 32'(en_at[0]), 32'd10);
    check("en_cycle1", 32'(en_at[1]), 32'd20);
    check("en_cycle2", 32'(en_at[2]), 32'd30);
    check("run_no_pulses", 32'(up_cnt + dn_cnt), 32'd0);

    for (int i = 0; i < 7; i++) begin
      push(1'b1, 1'b0, 1'b0, 8, 12);
      check($sformatf("mode_step%0d", i), 32'(select_item), 32'(sel_tab[i]));
      if (i == 0) en_cnt = 0;
      if (i == 5) check("en_in_edit", 32'(en_cnt), 32'd0);
    end

    // Debounce in SEC
    push(1'b1, 1'b0, 1'b0, 8, 12);
    up_cnt = 0;
    btn_up = 1'b1; tick(3); btn_up = 1'b0; tick(15);
    check("glitch_up", 32'(up_cnt), 32'd0);
    up_cnt = 0; n = 0; found = 1'b0;
    btn_up = 1'b1;
    while (!found && n < 20) begin
      tick(1);
      n++;
      if (up) found = 1'b1;
    end
    check("press_latency", 32'(n), 32'd7);
    if (n < 8) tick(8 - n);
    btn_up = 1'b0; tick(30);
    check("press_once", 32'(up_cnt), 32'd1);

    // Auto-repeat in MIN: pulses at +0, +20, +25 ... until the release is accepted
    push(1'b1, 1'b0, 1'b0, 8, 12);
    up_cnt = 0;
    btn_up = 1'b1; tick(50); btn_up = 1'b0; tick(40);
    check("repeat_up", 32'(up_cnt), 32'd7);
    dn_cnt = 0;
    btn_down = 1'b1; tick(50); btn_down = 1'b0; tick(40);
    check("repeat_down", 32'(dn_cnt), 32'd7);

    up_cnt = 0; dn_cnt = 0;
    push(1'b0, 1'b1, 1'b1, 8, 20);
    check("updown_same", 32'(up_cnt + dn_cnt), 32'd0);
    push(1'b1, 1'b1, 1'b0, 8, 20);
    check("mode_beats_up_sel", 32'(select_item), 32'd2);
    check("mode_beats_up_pulse", 32'(up_cnt), 32'd0);

    repeat (4) push(1'b1, 1'b0, 1'b0, 8, 12);
    check("back_to_run", 32'(select_item), 32'h7);
    up_cnt = 0;
    push(1'b0, 1'b1, 1'b0, 8, 20);
    check("up_in_run", 32'(up_cnt), 32'd0);

    // Idle timeout from HOUR
    repeat (3) push(1'b1, 1'b0, 1'b0, 8, 12);
    check("enter_hour", 32'(select_item), 32'd2);
    n = 0;
    while (select_item != 3'b111 && n < 400) begin tick(1); n++; end
    check("timeout_reached", 32'(select_item), 32'h7);
    n = 0; found = 1'b0;
    while (!found && n < 20) begin
      tick(1);
      n++;
      if (en_1) found = 1'b1;
    end
    check("en_after_timeout", 32'(n + 1), 32'd10);

    // Reset in the middle of a repeat burst
    push(1'b1, 1'b0, 1'b0, 8, 12);
    up_cnt = 0;
    btn_up = 1'b1; tick(30);
    check("burst_started", 32'(up_cnt), 32'd2);
    rst = 1'b1;
    #1;
    check("rst_async_sel", 32'(select_item), 32'h7);
    check("rst_async_flags", 32'({en_1, up, down, editing}), 32'h0);
    tick(2);
    rst = 1'b0;
    up_cnt = 0;
    tick(30); btn_up = 1'b0; tick(20);
    check("no_pulse_after_rst", 32'(up_cnt), 32'd0);

    // Random button activity, including occasional long idle gaps and resets
    for (int s = 0; s < 150; s++) begin
      int r, len, gap;
      r = int'($urandom_range(0, 99));
      if (r < 3) begin
        rst = 1'b1; tick(2); rst = 1'b0;
        continue;
      end
      btn_mode = ($urandom_range(0, 99) < 25);
      btn_up   = ($urandom_range(0, 99) < 35);
      btn_down = ($urandom_range(0, 99) < 25);
      len = int'($urandom_range(1, 60));
      tick(len);
      btn_mode = 1'b0; btn_up = 1'b0; btn_down = 1'b0;
      gap = ($urandom_range(0, 99) < 8) ? int'($urandom_range(150, 260)) : int'($urandom_range(0, 30));
      if (gap > 0) tick(gap);
    end

    tick(5);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/set_ctrl.md
Name: set_ctrl

Overview:
- Front-end control stage of the millennium clock; sits directly upstream of the sec counter and the other time-field counters.
- Converts raw push buttons (mode/up/down) into debounced single-cycle up/down pulses and the select_item field code.
- Generates the en_1 count-enable tick, which is suppressed while any field is being edited.

Parameters:
- DEBOUNCE_CYC, 4, consecutive stable cycles needed to accept a button level change
- TICK_DIV, 10, clk cycles per en_1 pulse in run mode (real build: input clock frequency)
- REPEAT_DLY, 20, held-button cycles after the first pulse before auto-repeat starts
- REPEAT_RATE, 5, cycles between auto-repeat pulses
- TIMEOUT_CYC, 200, idle cycles in edit mode before automatic return to run

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- btn_mode  in  1  raw mode button, active-high, asynchronous to clk
- btn_up  in  1  raw up button, active-high, asynchronous
- btn_down  in  1  raw down button, active-high, asynchronous
- en_1  out  1  one-cycle count-enable tick for the sec counter
- up  out  1  one-cycle increment pulse for the selected field
- down  out  1  one-cycle decrement pulse for the selected field
- select_item  out  3  field code: 000 sec, 001 min, 010 hour, 011 day, 100 month, 101 year, 111 run (no edit)
- editing  out  1  high when select_item != 111

Behaviour:
- Reset values: select_item=111, en_1=0, up=0, down=0, editing=0. Synchronizers, debounce counters, prescaler, repeat and timeout counters all clear to 0.
- Reset takes effect asynchronously at any time, including mid-edit or mid-repeat.
- Input conditioning, per button:
  - 2-flop synchronizer.
  - Debounce counter: increments while the synchronized level differs from the debounced level; clears when they match. When it reaches DEBOUNCE_CYC, the debounced level flips.
  - Press = registered rising edge of the debounced level.
  - Latency: a clean press produces its output effect at the 3+DEBOUNCE_CYC-th rising edge after the first edge that samples the raw button high.
  - Glitches shorter than DEBOUNCE_CYC cycles produce nothing.
- Mode state machine: RUN(111) -> SEC(000) -> MIN -> HOUR -> DAY -> MONTH -> YEAR(101) -> RUN.
  - Advances one step per mode press.
  - Codes 110 and other unused codes are never output.
- en_1 in RUN:
  - Prescaler counts 0..TICK_DIV-1; en_1 is high for the one cycle when the count equals TICK_DIV-1.
  - In edit states, en_1 is held 0 and the prescaler is held at 0, so the first tick after returning to RUN comes exactly TICK_DIV cycles later.
- up/down pulses:
  - Generated only in edit states; presses in RUN are discarded.
  - Up and down pressed in the same cycle: neither pulse is issued.
  - A mode press has priority over an up/down press in the same cycle; the up/down press is dropped.
  - up and down are never high together.
- Auto-repeat:
  - While the debounced up (or down) stays high and the other button is low, one extra pulse is issued REPEAT_DLY cycles after the initial pulse, then one every REPEAT_RATE cycles.
  - Release, a mode press, or pressing the opposite button stops repeat and clears the repeat counter.
- Timeout:
  - In edit states, the idle counter clears on any debounced press or while any debounced button is held.
  - Otherwise it increments; on reaching TIMEOUT_CYC, select_item returns to 111.
  - No up/down pulse is issued on the timeout cycle.
- All outputs are registered; no combinational path from the button inputs to any output.

Test Plan:
- Reset then run: rst high 3 cycles, release, no buttons -> select_item=111, editing=0, en_1 pulses at cycles 10, 20, 30 after release, up=down=0 throughout.
- Mode cycling: 7 clean mode presses of 8 cycles each, spaced 20 cycles apart -> select_item steps 000, 001, 010, 011, 100, 101, 111; en_1=0 for the whole edit interval; first en_1 exactly 10 cycles after select_item returns to 111.
- Debounce: in SEC, btn_up glitch 3 cycles high -> no up pulse. Clean 8-cycle press -> exactly one up pulse, 7 edges after first sampled high.
- Auto-repeat: in MIN, hold btn_up 50 cycles -> up pulses at t0, t0+20, t0+25, t0+30 ... up to release; no pulse after release. Repeat with btn_down -> matching down pattern.
- Conflicts: up and down pressed on the same edge -> no pulse. Mode and up pressed on the same edge -> select_item advances, no up pulse. Up press in RUN -> no pulse.
- Timeout and reset: enter HOUR, stay idle 200 cycles -> select_item=111 and en_1 resumes 10 cycles later. Assert rst during an auto-repeat burst -> all outputs 0 / 111 immediately, with no further pulses until a new press.
